// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-stage execute pipeline around an external 16-bit ALU.
//   Stage 1 registers a decoded op (operands, function, destination) and
//   drives the ALU inputs. Stage 2 captures the ALU result with the
//   destination index and offers it to writeback. Valid/ready on both sides.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                decode handshake
//   in_func, in_a, in_b, in_rd       decoded op
//   alu_a, alu_b, alu_op             registered ALU inputs (stage 1)
//   alu_z, alu_zero                  combinational ALU result
//   out_valid/out_ready              writeback handshake
//   out_z, out_zero, out_rd, out_err registered result (stage 2)
//   op_count                         results accepted by writeback (wraps)
module alu_exec_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RD_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_func,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [RD_W-1:0]   in_rd,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [2:0]        alu_op,
    input  logic [WIDTH-1:0]  alu_z,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_z,
    output logic              out_zero,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_err,
    output logic [15:0]       op_count
);

    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 16;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_err_q,   s1_err_d;
    logic [RD_W-1:0]   s1_rd_q,    s1_rd_d;
    logic [WIDTH-1:0]  alu_a_q,    alu_a_d;
    logic [WIDTH-1:0]  alu_b_q,    alu_b_d;
    logic [OP_W-1:0]   alu_op_q,   alu_op_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_z_q,    out_z_d;
    logic              out_zero_q, out_zero_d;
    logic [RD_W-1:0]   out_rd_q,   out_rd_d;
    logic              out_err_q,  out_err_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic s2_free_c, in_ready_c, in_fire_c, move_c, out_fire_c, func_ok_c;

    // Handshake terms; in_ready never looks at in_valid.
    always_comb begin
        s2_free_c  = !out_valid_q || out_ready;
        in_ready_c = !s1_valid_q || s2_free_c;
        in_fire_c  = in_valid && in_ready_c;
        move_c     = s1_valid_q && s2_free_c;
        out_fire_c = out_valid_q && out_ready;
    end

    // Legal function codes: AND, OR, ADD, SUB, SLT.
    always_comb begin
        func_ok_c = 1'b0;
        case (in_func)
            4'h0, 4'h1, 4'h2, 4'h6, 4'h7: func_ok_c = 1'b1;
            default:                      func_ok_c = 1'b0;
        endcase
    end

    // Next-state for both stages and the completion counter.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_err_d    = s1_err_q;
        s1_rd_d     = s1_rd_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        out_valid_d = out_valid_q;
        out_z_d     = out_z_q;
        out_zero_d  = out_zero_q;
        out_rd_d    = out_rd_q;
        out_err_d   = out_err_q;
        op_count_d  = op_count_q;

        // A new op may replace one that is leaving in the same cycle.
        if (in_fire_c) begin
            s1_valid_d = 1'b1;
            s1_err_d   = !func_ok_c;
            s1_rd_d    = in_rd;
            alu_a_d    = in_a;
            alu_b_d    = in_b;
            alu_op_d   = in_func[OP_W-1:0];
        end else if (move_c) begin
            s1_valid_d = 1'b0;
        end

        // Illegal ops still flow, but with a neutral result.
        if (move_c) begin
            out_valid_d = 1'b1;
            out_z_d     = s1_err_q ? '0 : alu_z;
            out_zero_d  = s1_err_q ? 1'b0 : alu_zero;
            out_rd_d    = s1_rd_q;
            out_err_d   = s1_err_q;
        end else if (out_fire_c) begin
            out_valid_d = 1'b0;
        end

        if (out_fire_c) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_rd_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
            out_zero_q  <= 1'b0;
            out_rd_q    <= '0;
            out_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_err_q    <= s1_err_d;
            s1_rd_q     <= s1_rd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            out_valid_q <= out_valid_d;
            out_z_q     <= out_z_d;
            out_zero_q  <= out_zero_d;
            out_rd_q    <= out_rd_d;
            out_err_q   <= out_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;
    assign out_zero  = out_zero_q;
    assign out_rd    = out_rd_q;
    assign out_err   = out_err_q;
    assign op_count  = op_count_q;

endmodule
